int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl.sv | 137 +++++++++++++
 tb/tb_int_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Eight-channel interrupt controller: synchronizes device sources, latches edge/level
// events into pending bits, masks them into irq, and exposes PEND/ENABLE/MODE/RAW on a strobed bus.
module int_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs_,
   input  logic        as_,
   input  logic        rw,
   input  logic [1:0]  addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        rdy_,
   input  logic [7:0]  src,
   output logic [7:0]  irq
);

   localparam logic [1:0] ADDR_PEND   = 2'd0;
   localparam logic [1:0] ADDR_ENABLE = 2'd1;
   localparam logic [1:0] ADDR_MODE   = 2'd2;
   localparam logic [1:0] ADDR_RAW    = 2'd3;

   logic [7:0]  s1_r;
   logic [7:0]  s2_r;
   logic [7:0]  s3_r;
   logic [7:0]  pend_r;
   logic [7:0]  enable_r;
   logic [7:0]  mode_r;

   logic        access_s;
   logic        wr_s;
   logic        rd_s;
   logic [7:0]  clr_s;
   logic [7:0]  swset_s;
   logic [7:0]  set_s;
   logic [7:0]  pend_next_s;
   logic [31:0] rd_sel_s;
   logic        unused_s;

   // Upper write-data bits carry no register state.
   assign unused_s = ^wr_data[31:8];

   // Bus access decode.
   always_comb begin
      access_s = 1'b0;
      wr_s     = 1'b0;
      rd_s     = 1'b0;
      if (!cs_ && !as_) begin
         access_s = 1'b1;
         wr_s     = ~rw;
         rd_s     = rw;
      end else begin
         access_s = 1'b0;
      end
   end

   // Software clear/set strobes from PEND and RAW writes.
   always_comb begin
      clr_s   = 8'h00;
      swset_s = 8'h00;
      if (wr_s) begin
         case (addr)
            ADDR_PEND: clr_s   = wr_data[7:0];
            ADDR_RAW:  swset_s = wr_data[7:0];
            default:   begin
               clr_s   = 8'h00;
               swset_s = 8'h00;
            end
         endcase
      end else begin
         clr_s   = 8'h00;
         swset_s = 8'h00;
      end
   end

   // Hardware set: rising edge for edge-mode channels, current level otherwise.
   // Sets are OR-ed after the clear so a coincident set always wins.
   always_comb begin
      set_s       = (mode_r & s2_r & ~s3_r) | (~mode_r & s2_r);
      pend_next_s = (pend_r & ~clr_s) | set_s | swset_s;
   end

   // Read mux; RAW returns the synchronized source level.
   always_comb begin
      rd_sel_s = 32'd0;
      case (addr)
         ADDR_PEND:   rd_sel_s = {24'd0, pend_r};
         ADDR_ENABLE: rd_sel_s = {24'd0, enable_r};
         ADDR_MODE:   rd_sel_s = {24'd0, mode_r};
         ADDR_RAW:    rd_sel_s = {24'd0, s2_r};
         default:     rd_sel_s = 32'd0;
      endcase
   end

   // Source synchronizer plus one history stage for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_r <= 8'h00;
         s2_r <= 8'h00;
         s3_r <= 8'h00;
      end else begin
         s1_r <= src;
         s2_r <= s1_r;
         s3_r <= s2_r;
      end
   end

   // Pending, enable and mode registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_r   <= 8'h00;
         enable_r <= 8'h00;
         mode_r   <= 8'h00;
      end else begin
         pend_r <= pend_next_s;
         if (wr_s && (addr == ADDR_ENABLE)) begin
            enable_r <= wr_data[7:0];
         end
         if (wr_s && (addr == ADDR_MODE)) begin
            mode_r <= wr_data[7:0];
         end
      end
   end

   // Registered outputs: masked interrupt request, ready pulse and read data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq     <= 8'h00;
         rdy_    <= 1'b1;
         rd_data <= 32'd0;
      end else begin
         irq     <= pend_r & enable_r;
         rdy_    <= ~access_s;
         rd_data <= rd_s ? rd_sel_s : 32'd0;
      end
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Randomized bench for int_ctrl: a behavioural model built from the register rules
// predicts irq, rd_data and rdy_ every cycle; directed scenarios add constant checks.
module tb_int_ctrl;

   logic        clk;
   logic        reset;
   logic        cs_;
   logic        as_;
   logic        rw;
   logic [1:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        rdy_;
   logic [7:0]  src;
   logic [7:0]  irq;

   int total;
   int bad;

   // Reference state: architectural registers plus the history of src as sampled at each edge.
   logic [7:0]  m_pend;
   logic [7:0]  m_en;
   logic [7:0]  m_mode;
   logic [7:0]  m_irq;
   logic [31:0] m_rd;
   logic        m_rdy;
   logic [7:0]  smp[$];
   logic [7:0]  src_nxt;

   int_ctrl dut (
      .clk     (clk),
      .reset   (reset),
      .cs_     (cs_),
      .as_     (as_),
      .rw      (rw),
      .addr    (addr),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .rdy_    (rdy_),
      .src     (src),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = 8'h00;
      m_en   = 8'h00;
      m_mode = 8'h00;
      m_irq  = 8'h00;
      m_rd   = 32'd0;
      m_rdy  = 1'b1;
      smp.delete();
      for (int i = 0; i < 3; i++) smp.push_back(8'h00);
   endtask

   // Advance the model over one rising edge using the inputs currently applied.
   task automatic model_edge();
      logic        acc;
      logic [7:0]  lvl;
      logic [7:0]  prev;
      logic [7:0]  set;
      logic [7:0]  clr;
      logic [7:0]  sws;
      logic [31:0] rd;
      acc  = !cs_ && !as_;
      lvl  = smp[1];      // src as it stood two edges ago (synchronized level)
      prev = smp[2];      // one edge before that
      set  = 8'h00;
      for (int b = 0; b < 8; b++) begin
         if (m_mode[b]) set[b] = lvl[b] && !prev[b];
         else           set[b] = lvl[b];
      end
      clr = (acc && !rw && addr == 2'd0) ? wr_data[7:0] : 8'h00;
      sws = (acc && !rw && addr == 2'd3) ? wr_data[7:0] : 8'h00;
      rd  = 32'd0;
      if (acc && rw) begin
         if (addr == 2'd0)      rd = {24'd0, m_pend};
         else if (addr == 2'd1) rd = {24'd0, m_en};
         else if (addr == 2'd2) rd = {24'd0, m_mode};
         else                   rd = {24'd0, lvl};
      end
      m_rd   = rd;
      m_rdy  = !acc;
      m_irq  = m_pend & m_en;
      m_pend = (m_pend & ~clr) | set | sws;
      if (acc && !rw && addr == 2'd1) m_en   = wr_data[7:0];
      if (acc && !rw && addr == 2'd2) m_mode = wr_data[7:0];
      smp.push_front(src);
      void'(smp.pop_back());
   endtask

   task automatic step(input logic c, input logic a, input logic r,
                       input logic [1:0] ad, input logic [31:0] wd);
      @(negedge clk);
      cs_     = c;
      as_     = a;
      rw      = r;
      addr    = ad;
      wr_data = wd;
      src     = src_nxt;
      model_edge();
      @(posedge clk);
      #1;
      check("irq", {24'd0, irq}, {24'd0, m_irq});
      check("rd_data", rd_data, m_rd);
      check("rdy_", {31'd0, rdy_}, {31'd0, m_rdy});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
   endtask

   task automatic wr(input logic [1:0] ad, input logic [31:0] wd);
      step(1'b0, 1'b0, 1'b0, ad, wd);
   endtask

   task automatic rd(input logic [1:0] ad);
      step(1'b0, 1'b0, 1'b1, ad, $urandom);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      cs_   = 1'b1;
      as_   = 1'b1;
      #1;
      check("rst_irq", {24'd0, irq}, 32'd0);
      check("rst_rdy", {31'd0, rdy_}, 32'd1);
      check("rst_rd", rd_data, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      reset   = 1'b1;
      cs_     = 1'b1;
      as_     = 1'b1;
      rw      = 1'b0;
      addr    = 2'd0;
      wr_data = 32'd0;
      src     = 8'h00;
      src_nxt = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      do_reset();
      idle(2);

      // Bus timing: back-to-back reads, upper write bits ignored, idle returns zero.
      wr(2'd1, 32'hFFFF_FF5A);
      wr(2'd2, 32'h1234_563C);
      rd(2'd1);
      check("b2b_en_rdy", {31'd0, rdy_}, 32'd0);
      check("b2b_en", rd_data, 32'h0000_005A);
      rd(2'd2);
      check("b2b_mode_rdy", {31'd0, rdy_}, 32'd0);
      check("b2b_mode", rd_data, 32'h0000_003C);
      idle(1);
      check("idle_rd", rd_data, 32'd0);
      check("idle_rdy", {31'd0, rdy_}, 32'd1);

      // Set-vs-clear collision on an edge-mode channel.
      wr(2'd1, 32'h0000_0000);
      wr(2'd2, 32'h0000_0020);
      src_nxt = 8'h20;
      idle(2);
      wr(2'd0, 32'h0000_0020);
      rd(2'd0);
      check("collide", rd_data, 32'h0000_0020);
      src_nxt = 8'h00;
      idle(3);
      wr(2'd0, 32'h0000_00FF);

      // Edge latency and no re-trigger while held high.
      wr(2'd1, 32'h0000_0001);
      wr(2'd2, 32'h0000_0001);
      src_nxt = 8'h01;
      idle(3);
      check("edge_e2", {24'd0, irq}, 32'd0);
      idle(1);
      check("edge_e3", {24'd0, irq}, 32'h0000_0001);
      wr(2'd0, 32'h0000_0001);
      idle(4);
      check("edge_once", {24'd0, irq}, 32'd0);
      src_nxt = 8'h00;
      idle(3);

      // Software set behind the mask, then unmask.
      wr(2'd1, 32'h0000_0000);
      wr(2'd3, 32'h0000_0081);
      rd(2'd0);
      check("swset_pend", rd_data, 32'h0000_0081);
      idle(1);
      check("swset_mask", {24'd0, irq}, 32'd0);
      wr(2'd1, 32'h0000_00FF);
      idle(1);
      check("swset_irq", {24'd0, irq}, 32'h0000_0081);
      wr(2'd0, 32'h0000_00FF);
      idle(2);

      // Level mode: clear re-asserts while src held, stays clear once src drops.
      wr(2'd2, 32'h0000_0000);
      wr(2'd1, 32'h0000_0004);
      src_nxt = 8'h04;
      idle(4);
      check("lvl_irq", {24'd0, irq}, 32'h0000_0004);
      wr(2'd0, 32'h0000_0004);
      idle(3);
      check("lvl_reassert", {24'd0, irq}, 32'h0000_0004);
      src_nxt = 8'h00;
      idle(3);
      wr(2'd0, 32'h0000_0004);
      idle(2);
      check("lvl_clear", {24'd0, irq}, 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) src_nxt = src_nxt ^ (8'h01 << $urandom_range(0, 7));
         if ($urandom_range(0, 1) == 0)
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
         else
            step(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
      end

      // Reset mid-operation with everything pending and an access in flight.
      src_nxt = 8'h00;
      wr(2'd1, 32'h0000_00FF);
      wr(2'd3, 32'h0000_00FF);
      idle(1);
      rd(2'd0);
      check("pre_rst_irq", {24'd0, irq}, 32'h0000_00FF);
      check("pre_rst_rd", rd_data, 32'h0000_00FF);
      @(negedge clk);
      cs_ = 1'b0;
      as_ = 1'b0;
      rw  = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      check("async_irq", {24'd0, irq}, 32'd0);
      check("async_rdy", {31'd0, rdy_}, 32'd1);
      check("async_rd", rd_data, 32'd0);
      @(negedge clk);
      cs_ = 1'b1;
      as_ = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      idle(2);
      check("post_rst_rdy", {31'd0, rdy_}, 32'd1);
      rd(2'd0);
      check("post_rst_pend", rd_data, 32'd0);
      idle(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
